// File: rtl/problem_round_controller.sv
// ---------------------------------------------------------------------------
// problem_round_controller
//   Sequences one game round of the problem datapath: fetches a problem from
//   the generator (req/ready with timeout), holds it for display, debounces
//   the submit button, judges the DIP-switch answer and tracks wrong answers
//   up to a lockout limit.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start_round       : one-cycle request to fetch a new problem
//   gen_req/gen_ready : generator handshake; gen_num1/num2/op/answer data
//   button_sub        : raw asynchronous submit button
//   dip_switch        : player answer
//   prob_num1/num2/op : held problem, prob_valid while it is live
//   verdict_valid     : one-cycle strobe, verdict_correct qualifies it
//   wrong_count       : wrong answers on the current problem
//   lockout           : wrong-answer limit reached
//   gen_error         : generator timed out
//   busy              : high in FETCH, ARMED and JUDGE
// ---------------------------------------------------------------------------
module problem_round_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int GEN_TIMEOUT     = 1024,
   parameter int MAX_WRONG       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_round,
   output logic       gen_req,
   input  logic       gen_ready,
   input  logic [7:0] gen_num1,
   input  logic [7:0] gen_num2,
   input  logic [2:0] gen_op,
   input  logic [7:0] gen_answer,
   input  logic       button_sub,
   input  logic [7:0] dip_switch,
   output logic [7:0] prob_num1,
   output logic [7:0] prob_num2,
   output logic [2:0] prob_op,
   output logic       prob_valid,
   output logic       verdict_valid,
   output logic       verdict_correct,
   output logic [1:0] wrong_count,
   output logic       lockout,
   output logic       gen_error,
   output logic       busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_ARMED  = 3'd2;
   localparam logic [2:0] S_JUDGE  = 3'd3;
   localparam logic [2:0] S_LOCKED = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   localparam logic [23:0] DEB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [16:0] TMO_LIMIT   = 17'(GEN_TIMEOUT);
   localparam logic [2:0]  WRONG_LIMIT = 3'(MAX_WRONG);
   localparam logic [1:0]  WRONG_SAT   = 2'(MAX_WRONG);

   logic [2:0]  state;
   logic        sync1, sync2;
   logic        deb_level;
   logic [23:0] deb_cnt;
   logic        press;
   logic [15:0] tmo_cnt;
   logic [7:0]  answer;
   logic [7:0]  capture;

   logic        deb_done;
   logic [16:0] tmo_next;
   logic [2:0]  wrong_next;

   // The synchronized level has disagreed with the debounced level for the
   // full window on this cycle, so the debounced level flips at this edge.
   assign deb_done   = (sync2 != deb_level) && (deb_cnt == DEB_LAST);
   // Widened by one bit so the compare against the limit cannot wrap.
   assign tmo_next   = {1'b0, tmo_cnt} + 17'd1;
   assign wrong_next = {1'b0, wrong_count} + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         sync1           <= 1'b0;
         sync2           <= 1'b0;
         deb_level       <= 1'b0;
         deb_cnt         <= '0;
         press           <= 1'b0;
         tmo_cnt         <= '0;
         answer          <= '0;
         capture         <= '0;
         gen_req         <= 1'b0;
         prob_num1       <= '0;
         prob_num2       <= '0;
         prob_op         <= '0;
         prob_valid      <= 1'b0;
         verdict_valid   <= 1'b0;
         verdict_correct <= 1'b0;
         wrong_count     <= '0;
         lockout         <= 1'b0;
         gen_error       <= 1'b0;
         busy            <= 1'b0;
      end else begin
         sync1 <= button_sub;
         sync2 <= sync1;

         // Any cycle where the synchronized level agrees again restarts the
         // window, so a bounce never accumulates toward acceptance.
         if (sync2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_done) begin
            deb_cnt   <= '0;
            deb_level <= sync2;
         end else begin
            deb_cnt <= deb_cnt + 24'd1;
         end

         // One-cycle pulse for the 0->1 edge; only ARMED looks at it, so a
         // press completing elsewhere simply evaporates.
         press <= deb_done & sync2;

         verdict_valid   <= 1'b0;
         verdict_correct <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_round) begin
                  state   <= S_FETCH;
                  gen_req <= 1'b1;
                  busy    <= 1'b1;
                  tmo_cnt <= '0;
               end
            end
            S_FETCH: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               // Ready wins over the timeout when both land on one cycle.
               if (gen_ready) begin
                  prob_num1  <= gen_num1;
                  prob_num2  <= gen_num2;
                  prob_op    <= gen_op;
                  answer     <= gen_answer;
                  prob_valid <= 1'b1;
                  gen_req    <= 1'b0;
                  state      <= S_ARMED;
               end else if (tmo_next == TMO_LIMIT) begin
                  gen_req   <= 1'b0;
                  gen_error <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_ERROR;
               end
            end
            S_ARMED: begin
               if (press) begin
                  capture <= dip_switch;
                  state   <= S_JUDGE;
               end
            end
            S_JUDGE: begin
               verdict_valid   <= 1'b1;
               verdict_correct <= (capture == answer);
               if (capture == answer) begin
                  prob_valid  <= 1'b0;
                  wrong_count <= '0;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else if (wrong_next < WRONG_LIMIT) begin
                  wrong_count <= wrong_next[1:0];
                  state       <= S_ARMED;
               end else begin
                  prob_valid  <= 1'b0;
                  wrong_count <= WRONG_SAT;
                  lockout     <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_LOCKED;
               end
            end
            S_LOCKED, S_ERROR: begin
               if (start_round) begin
                  state       <= S_FETCH;
                  gen_req     <= 1'b1;
                  busy        <= 1'b1;
                  tmo_cnt     <= '0;
                  lockout     <= 1'b0;
                  wrong_count <= '0;
                  gen_error   <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               gen_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_problem_round_controller.sv
// ---------------------------------------------------------------------------
// tb_problem_round_controller
//   Directed plus randomized stimulus against a behavioural round model.
//   Every cycle the whole output vector is compared with the model; named
//   checks mark the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_problem_round_controller;

   localparam int DEB  = 4;
   localparam int TMO  = 8;
   localparam int MAXW = 3;

   logic       clk = 1'b0;
   logic       rst, start_round, gen_ready, button_sub;
   logic [7:0] gen_num1, gen_num2, gen_answer, dip_switch;
   logic [2:0] gen_op;
   logic       gen_req, prob_valid, verdict_valid, verdict_correct;
   logic       lockout, gen_error, busy;
   logic [7:0] prob_num1, prob_num2;
   logic [2:0] prob_op;
   logic [1:0] wrong_count;

   problem_round_controller #(
      .DEBOUNCE_CYCLES(DEB), .GEN_TIMEOUT(TMO), .MAX_WRONG(MAXW)
   ) dut (
      .clk(clk), .rst(rst), .start_round(start_round), .gen_req(gen_req),
      .gen_ready(gen_ready), .gen_num1(gen_num1), .gen_num2(gen_num2),
      .gen_op(gen_op), .gen_answer(gen_answer), .button_sub(button_sub),
      .dip_switch(dip_switch), .prob_num1(prob_num1), .prob_num2(prob_num2),
      .prob_op(prob_op), .prob_valid(prob_valid),
      .verdict_valid(verdict_valid), .verdict_correct(verdict_correct),
      .wrong_count(wrong_count), .lockout(lockout), .gen_error(gen_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_FETCH = 1, P_ARMED = 2, P_JUDGE = 3,
                  P_LOCKED = 4, P_ERROR = 5;

   int         m_ph, m_tmo, m_wc;
   logic [7:0] m_n1, m_n2, m_ans, m_cap;
   logic [2:0] m_op;
   logic       m_req, m_pv, m_vv, m_vc, m_lock, m_err, m_deb, m_press;
   bit         bhist[$];   // raw button at recent edges
   bit         shist[$];   // synchronized level seen at recent edges

   int   n_pass = 0, n_chk = 0, n_verdict = 0, req_cycles = 0;
   logic last_vc = 1'b0;

   function automatic logic [27:0] dut_vec();
      return {gen_req, prob_num1, prob_num2, prob_op, prob_valid, verdict_valid,
              verdict_correct, wrong_count, lockout, gen_error, busy};
   endfunction

   function automatic logic [27:0] model_vec();
      logic b;
      b = (m_ph == P_FETCH) || (m_ph == P_ARMED) || (m_ph == P_JUDGE);
      return {m_req, m_n1, m_n2, m_op, m_pv, m_vv, m_vc, 2'(m_wc), m_lock,
              m_err, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_edge();
      bit acted, syn, all_diff;
      if (rst) begin
         m_ph = P_IDLE; m_tmo = 0; m_wc = 0;
         m_n1 = 0; m_n2 = 0; m_op = 0; m_ans = 0; m_cap = 0;
         m_req = 0; m_pv = 0; m_vv = 0; m_vc = 0; m_lock = 0; m_err = 0;
         m_deb = 0; m_press = 0;
         bhist.delete(); shist.delete();
         return;
      end
      acted = m_press;
      m_vv = 0; m_vc = 0;
      case (m_ph)
         P_IDLE: if (start_round) begin m_ph = P_FETCH; m_req = 1; m_tmo = 0; end
         P_FETCH: begin
            m_tmo++;
            if (gen_ready) begin
               m_n1 = gen_num1; m_n2 = gen_num2; m_op = gen_op; m_ans = gen_answer;
               m_req = 0; m_pv = 1; m_ph = P_ARMED;
            end else if (m_tmo == TMO) begin
               m_req = 0; m_err = 1; m_ph = P_ERROR;
            end
         end
         P_ARMED: if (acted) begin m_cap = dip_switch; m_ph = P_JUDGE; end
         P_JUDGE: begin
            m_vv = 1; m_vc = (m_cap == m_ans);
            if (m_vc) begin m_ph = P_IDLE; m_pv = 0; m_wc = 0; end
            else if (m_wc + 1 < MAXW) begin m_wc++; m_ph = P_ARMED; end
            else begin m_ph = P_LOCKED; m_lock = 1; m_pv = 0; m_wc = MAXW; end
         end
         default: if (start_round) begin
            m_ph = P_FETCH; m_req = 1; m_tmo = 0; m_lock = 0; m_wc = 0; m_err = 0;
         end
      endcase
      // Two-stage synchronizer, then level accepted once the last DEB
      // synchronized samples all disagree with it.
      syn = (bhist.size() >= 2) ? bhist[bhist.size()-2] : 1'b0;
      bhist.push_back(button_sub);
      if (bhist.size() > 2) void'(bhist.pop_front());
      shist.push_back(syn);
      if (shist.size() > DEB) void'(shist.pop_front());
      m_press = 0;
      if (shist.size() == DEB) begin
         all_diff = 1;
         foreach (shist[i]) if (shist[i] == m_deb) all_diff = 0;
         if (all_diff) begin m_deb = ~m_deb; m_press = m_deb; end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      if (verdict_valid === 1'b1) begin n_verdict++; last_vc = verdict_correct; end
      if (gen_req === 1'b1) req_cycles++;
      check("cyc", {4'b0, dut_vec()}, {4'b0, model_vec()});
   endtask

   task automatic fetch(input int delay, input logic [7:0] n1, input logic [7:0] n2,
                        input logic [2:0] op, input logic [7:0] ans);
      start_round = 1; tick(); start_round = 0;
      repeat (delay) begin
         gen_num1 = 8'($urandom); gen_num2 = 8'($urandom);
         gen_op = 3'($urandom); gen_answer = 8'($urandom);
         tick();
      end
      gen_ready = 1; gen_num1 = n1; gen_num2 = n2; gen_op = op; gen_answer = ans;
      tick();
      gen_ready = 0; gen_answer = 8'($urandom);
   endtask

   task automatic press(input logic [7:0] val, input int hold, input int rel);
      dip_switch = val;
      button_sub = 1; repeat (hold) tick();
      button_sub = 0; repeat (rel) tick();
   endtask

   initial begin
      int vb;
      logic [7:0] a, n1;
      rst = 1; start_round = 0; gen_ready = 0; button_sub = 0;
      gen_num1 = 0; gen_num2 = 0; gen_op = 0; gen_answer = 0; dip_switch = 0;
      tick(); tick();
      check("reset_outputs", {4'b0, dut_vec()}, 32'd0);
      rst = 0; tick();

      // 1: fetch 12/5/1 answer 17
      fetch(2, 8'd12, 8'd5, 3'd1, 8'd17);
      check("fetch_req_drop", {31'b0, gen_req}, 32'd0);
      check("fetch_num1", {24'b0, prob_num1}, 32'd12);
      check("fetch_num2", {24'b0, prob_num2}, 32'd5);
      check("fetch_op", {29'b0, prob_op}, 32'd1);
      check("fetch_valid_busy", {30'b0, prob_valid, busy}, 32'd3);

      // 2: correct answer
      vb = n_verdict;
      press(8'd17, 6, 6);
      check("correct_one_verdict", n_verdict - vb, 32'd1);
      check("correct_result", {31'b0, last_vc}, 32'd1);
      check("correct_idle", {29'b0, prob_valid, wrong_count}, 32'd0);
      check("correct_not_busy", {31'b0, busy}, 32'd0);

      // 3: bounce rejected, then one wrong answer
      a = 8'($urandom);
      fetch(int'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 3'($urandom), a);
      vb = n_verdict;
      for (int i = 0; i < 10; i++) begin
         button_sub = ~button_sub; tick(); tick();
      end
      button_sub = 0; repeat (6) tick();
      check("bounce_no_verdict", n_verdict - vb, 32'd0);
      press(a - 8'd1, 6, 6);
      check("wrong1_verdict", n_verdict - vb, 32'd1);
      check("wrong1_result", {31'b0, last_vc}, 32'd0);
      check("wrong1_count", {30'b0, wrong_count}, 32'd1);
      check("wrong1_armed", {30'b0, prob_valid, busy}, 32'd3);

      // 4: two more wrong answers -> lockout
      press(a ^ 8'h5a, 6, 6);
      check("wrong2_count", {30'b0, wrong_count}, 32'd2);
      press(a + 8'd3, 6, 6);
      check("wrong3_count", {30'b0, wrong_count}, 32'd3);
      check("wrong3_lockout", {30'b0, lockout, prob_valid}, 32'd2);
      vb = n_verdict;
      press(a, 6, 6);
      check("locked_no_verdict", n_verdict - vb, 32'd0);

      // 4/5: restart from LOCKED, generator never answers -> timeout
      req_cycles = 0;
      start_round = 1; tick(); start_round = 0;
      check("unlock", {29'b0, lockout, wrong_count}, 32'd0);
      check("unlock_req", {31'b0, gen_req}, 32'd1);
      repeat (10) tick();
      check("timeout_req_cycles", req_cycles, TMO);
      check("timeout_error", {30'b0, gen_error, gen_req}, 32'd2);
      gen_ready = 1; tick(); tick(); gen_ready = 0;
      check("error_ignores_ready", {29'b0, gen_error, prob_valid, busy}, 32'd4);
      start_round = 1; tick(); start_round = 0;
      check("retry", {30'b0, gen_error, gen_req}, 32'd1);
      // ready on the very cycle the counter reaches the limit
      repeat (TMO - 1) tick();
      a = 8'($urandom); n1 = 8'($urandom);
      gen_ready = 1; gen_num1 = n1; gen_answer = a; tick(); gen_ready = 0;
      check("boundary_success", {30'b0, prob_valid, gen_error}, 32'd2);
      check("boundary_num1", {24'b0, prob_num1}, {24'b0, n1});
      press(a, 6, 6);
      check("boundary_answer", {31'b0, last_vc}, 32'd1);

      // 6: reset during FETCH and during a debounce
      start_round = 1; tick(); start_round = 0; tick(); tick();
      rst = 1; tick();
      check("rst_fetch", {4'b0, dut_vec()}, 32'd0);
      rst = 0; tick();
      button_sub = 1; repeat (3) tick();
      rst = 1; tick();
      check("rst_debounce", {4'b0, dut_vec()}, 32'd0);
      rst = 0;
      vb = n_verdict;
      repeat (8) tick();
      a = 8'($urandom);
      fetch(1, 8'd1, 8'd2, 3'd3, a);
      dip_switch = a; repeat (8) tick();
      check("held_press_discarded", n_verdict - vb, 32'd0);
      button_sub = 0; repeat (8) tick();
      press(a, 6, 6);
      check("press_after_reset", n_verdict - vb, 32'd1);

      // randomized rounds
      for (int r = 0; r < 12; r++) begin
         a = 8'($urandom);
         fetch(int'($urandom_range(0, 9)), 8'($urandom), 8'($urandom), 3'($urandom), a);
         for (int k = 0; k < 3; k++) begin
            press(($urandom_range(0, 1) != 0) ? a : (a ^ 8'($urandom_range(1, 255))),
                  int'($urandom_range(2, 7)), int'($urandom_range(6, 8)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
